// File: rtl/fft_pkg.sv
// Shared types and constants for the 4x4 FFT corner-turn buffer.
// The width and dimension here set the ports of fft_transpose_buffer and tb_bank_mem.
package fft_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned N      = 4;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/tb_bank_mem.sv
// One 4x4 complex matrix bank: full-row write port, full-column read port.
// The read is a plain mux on the registered column pointer; the storage has no reset.
module tb_bank_mem
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                wr_en,
  input  logic [1:0]          wr_row,
  input  logic [N*DATA_W-1:0] wr_re,
  input  logic [N*DATA_W-1:0] wr_im,
  input  logic [1:0]          rd_col,
  output logic [N*DATA_W-1:0] rd_re,
  output logic [N*DATA_W-1:0] rd_im
);

  cplx_t mem [N][N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < N; c++) begin
        mem[wr_row][c].re <= wr_re[c*DATA_W +: DATA_W];
        mem[wr_row][c].im <= wr_im[c*DATA_W +: DATA_W];
      end
    end
  end

  // Lane r of the read port is row r of the selected column.
  always_comb begin
    rd_re = '0;
    rd_im = '0;
    for (int r = 0; r < N; r++) begin
      rd_re[r*DATA_W +: DATA_W] = mem[r][rd_col].re;
      rd_im[r*DATA_W +: DATA_W] = mem[r][rd_col].im;
    end
  end

endmodule

// File: rtl/fft_transpose_buffer.sv
// Corner-turn buffer: accepts four row beats, replays the 4x4 matrix as four column beats.
// Define PINGPONG_EN for two banks (fill one while draining the other); default is one bank.
module fft_transpose_buffer
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_re,
  input  logic [N*DATA_W-1:0] in_im,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*DATA_W-1:0] out_re,
  output logic [N*DATA_W-1:0] out_im,
  output logic [1:0]          out_col,
  output logic                out_last
);

  logic                in_fire;
  logic                out_fire;
  logic                wr_done;
  logic                rd_done;
  logic [1:0]          wr_row_q;
  logic [1:0]          rd_col_q;
  logic [N*DATA_W-1:0] rd_re;
  logic [N*DATA_W-1:0] rd_im;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign wr_done  = in_fire & (wr_row_q == 2'd3);
  assign rd_done  = out_fire & (rd_col_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_row_q <= '0;
    end else if (in_fire) begin
      wr_row_q <= wr_row_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_col_q <= '0;
    end else if (out_fire) begin
      rd_col_q <= rd_col_q + 2'd1;
    end
  end

`ifdef PINGPONG_EN

  logic                wr_bank_q;
  logic                rd_bank_q;
  logic [1:0]          full_q;
  logic [1:0]          full_d;
  logic [N*DATA_W-1:0] bank_re [2];
  logic [N*DATA_W-1:0] bank_im [2];

  // Fill and drain always target different banks, so set and clear never collide.
  always_comb begin
    full_d = full_q;
    if (wr_done) full_d[wr_bank_q] = 1'b1;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      full_q <= full_d;
      if (wr_done) wr_bank_q <= ~wr_bank_q;
      if (rd_done) rd_bank_q <= ~rd_bank_q;
    end
  end

  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tb_bank_mem u_bank (
      .clk    (clk),
      .wr_en  (in_fire && (wr_bank_q == 1'(b))),
      .wr_row (wr_row_q),
      .wr_re  (in_re),
      .wr_im  (in_im),
      .rd_col (rd_col_q),
      .rd_re  (bank_re[b]),
      .rd_im  (bank_im[b])
    );
  end

  assign rd_re = bank_re[rd_bank_q];
  assign rd_im = bank_im[rd_bank_q];

`else

  state_e state_q;
  state_e state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (wr_done) state_d = DRAIN;
      DRAIN:   if (rd_done) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == DRAIN);

  tb_bank_mem u_bank (
    .clk    (clk),
    .wr_en  (in_fire),
    .wr_row (wr_row_q),
    .wr_re  (in_re),
    .wr_im  (in_im),
    .rd_col (rd_col_q),
    .rd_re  (rd_re),
    .rd_im  (rd_im)
  );

`endif

  // Gate the read mux so stale or uninitialised storage never shows while idle.
  assign out_re   = out_valid ? rd_re : '0;
  assign out_im   = out_valid ? rd_im : '0;
  assign out_col  = rd_col_q;
  assign out_last = out_valid & (rd_col_q == 2'd3);

endmodule

// File: tb/tb_fft_transpose_buffer.sv
// Self-checking bench for fft_transpose_buffer: frame-queue reference model, cycle-exact checks.
// Honours PINGPONG_EN to select the one- or two-frame buffering model.
module tb_fft_transpose_buffer;
  import fft_pkg::*;

  localparam int RW = N * DATA_W;
  localparam int FW = N * RW;
`ifdef PINGPONG_EN
  localparam int Cap = 2;
`else
  localparam int Cap = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_re;
  logic [RW-1:0] in_im;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_re;
  logic [RW-1:0] out_im;
  logic [1:0]    out_col;
  logic          out_last;

  fft_transpose_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Frames are packed with element (r,c) at [(r*N+c)*DATA_W +: DATA_W].
  logic [FW-1:0] src_re[$];
  logic [FW-1:0] src_im[$];
  logic [FW-1:0] fq_re[$];
  logic [FW-1:0] fq_im[$];
  int wr_cnt;
  int rd_cnt;
  int stall_left;
  int checks;
  int failures;
  bit in_en;
  bit out_en;
  bit rnd;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic verify();
    logic [FW-1:0] f;
    logic [FW-1:0] g;
    logic [RW-1:0] exp_re;
    logic [RW-1:0] exp_im;
    exp_re = '0;
    exp_im = '0;
    if (fq_re.size() > 0) begin
      f = fq_re[0];
      g = fq_im[0];
      for (int r = 0; r < N; r++) begin
        exp_re[r*DATA_W +: DATA_W] = f[(r*N + rd_cnt)*DATA_W +: DATA_W];
        exp_im[r*DATA_W +: DATA_W] = g[(r*N + rd_cnt)*DATA_W +: DATA_W];
      end
    end
    check("in_ready", RW'(in_ready), RW'(fq_re.size() < Cap));
    check("out_valid", RW'(out_valid), RW'(fq_re.size() > 0));
    check("out_col", RW'(out_col), RW'(rd_cnt));
    check("out_last", RW'(out_last), RW'(fq_re.size() > 0 && rd_cnt == 3));
    check("out_re", out_re, exp_re);
    check("out_im", out_im, exp_im);
  endtask

  task automatic drive();
    logic [FW-1:0] f;
    logic [FW-1:0] g;
    in_valid = (rnd ? ($urandom_range(3) != 0) : in_en) && (src_re.size() > 0);
    if (in_valid) begin
      f = src_re[0];
      g = src_im[0];
      in_re = f[wr_cnt*RW +: RW];
      in_im = g[wr_cnt*RW +: RW];
    end else begin
      in_re = {$urandom, $urandom};
      in_im = {$urandom, $urandom};
    end
    out_ready = rnd ? ($urandom_range(3) != 0) : out_en;
    if (stall_left > 0 && fq_re.size() > 0 && rd_cnt == 1) begin
      out_ready = 1'b0;
      stall_left--;
    end
  endtask

  task automatic tick();
    bit in_fire;
    bit out_fire;
    in_fire  = in_valid && (fq_re.size() < Cap);
    out_fire = out_ready && (fq_re.size() > 0);
    @(posedge clk);
    if (rst) begin
      wr_cnt = 0;
      rd_cnt = 0;
      fq_re.delete();
      fq_im.delete();
    end else begin
      if (out_fire) begin
        if (rd_cnt == 3) begin
          rd_cnt = 0;
          void'(fq_re.pop_front());
          void'(fq_im.pop_front());
        end else begin
          rd_cnt++;
        end
      end
      if (in_fire) begin
        if (wr_cnt == 3) begin
          wr_cnt = 0;
          fq_re.push_back(src_re.pop_front());
          fq_im.push_back(src_im.pop_front());
        end else begin
          wr_cnt++;
        end
      end
    end
    #1;
    verify();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      tick();
    end
  endtask

  task automatic push_const(input int base, input bit neg_im);
    logic [FW-1:0] f;
    logic [FW-1:0] g;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        f[(r*N+c)*DATA_W +: DATA_W] = DATA_W'(base + 16*r + c);
        g[(r*N+c)*DATA_W +: DATA_W] = neg_im ? DATA_W'(-(base + 16*r + c))
                                             : DATA_W'(base + 16*r + c + 8);
      end
    end
    src_re.push_back(f);
    src_im.push_back(g);
  endtask

  task automatic push_random(input bit extreme);
    logic [FW-1:0] f;
    logic [FW-1:0] g;
    for (int k = 0; k < N*N; k++) begin
      f[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      g[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      if (extreme) begin
        f[k*DATA_W +: DATA_W] = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
        g[k*DATA_W +: DATA_W] = (k % 2 == 0) ? 16'h8000 : 16'h7FFF;
      end else if ($urandom_range(3) == 0) begin
        f[k*DATA_W +: DATA_W] = $urandom_range(1) ? 16'h7FFF : 16'h8000;
      end
    end
    src_re.push_back(f);
    src_im.push_back(g);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    checks = 0;
    failures = 0;
    wr_cnt = 0;
    rd_cnt = 0;
    stall_left = 0;
    in_en = 1'b0;
    out_en = 1'b0;
    rnd = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_re = '0;
    in_im = '0;

    // Reset state.
    run(2);
    rst = 1'b0;
    run(1);

    // Ramp frame, then a second frame offered while the first drains.
    push_const(0, 1'b1);
    push_const(16'h0040, 1'b0);
    in_en = 1'b1;
    out_en = 1'b1;
    run(20);

    // Five-cycle downstream stall on column 1.
    push_random(1'b0);
    stall_left = 5;
    run(20);
    stall_left = 0;

    // Reset after two rows of a frame; the fresh frame that follows must be clean.
    push_random(1'b0);
    push_const(16'h0300, 1'b1);
    for (int k = 0; k < 10 && wr_cnt != 2; k++) run(1);
    void'(src_re.pop_front());
    void'(src_im.pop_front());
    rst = 1'b1;
    drive();
    tick();
    rst = 1'b0;
    run(12);

    // Back-to-back frames with both sides held ready.
    push_const(16'h0100, 1'b0);
    push_const(16'h0200, 1'b0);
    push_const(16'h0100, 1'b1);
    run(24);

    // Extreme values.
    push_random(1'b1);
    run(12);

    // Randomised handshakes over several frames.
    for (int k = 0; k < 8; k++) push_random(k == 3);
    rnd = 1'b1;
    run(200);
    rnd = 1'b0;
    run(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_transpose_buffer.md
# fft_transpose_buffer

Corner-turn buffer between the row and column passes of the 4x4 2D FFT. It captures four consecutive row transforms from the row-stage 4-point FFT, one complex 4-vector per beat. It then replays the stored 4x4 complex matrix column by column to the column-stage 4-point FFT. Both sides use valid/ready handshakes, and one column is emitted per accepted beat.

## Interface
- DATA_W, 16, width of each real/imag component (two's complement)
- N, 4, matrix dimension; fixed at 4, other values unsupported
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  row beat offered
- in_ready  out  1  buffer can accept a row beat
- in_re  in  N*DATA_W  row bin k real part in bits [k*DATA_W +: DATA_W]
- in_im  in  N*DATA_W  row bin k imag part, same packing
- out_valid  out  1  column beat available
- out_ready  in  1  downstream accepts column beat
- out_re  out  N*DATA_W  lane r = real part of element (row r, current column)
- out_im  out  N*DATA_W  lane r = imag part, same packing
- out_col  out  2  index of column currently presented
- out_last  out  1  high with column 3 of a frame

## Operation
- Storage: mem[bank][row][col], complex, DATA_W per part. Data is stored and replayed bit-exact, with no arithmetic, scaling or sign change.
- Write side:
  - A beat transfers when in_valid && in_ready.
  - wr_row (2 bit) selects the row written; all 4 columns are written in one beat.
  - wr_row increments on each transfer and wraps 3->0.
  - The wrap marks the bank full.
- Read side:
  - out_re/out_im are the column rd_col of the read bank.
  - A beat transfers when out_valid && out_ready.
  - rd_col increments on each transfer and wraps 3->0.
  - The wrap marks the bank empty.
- out_col = rd_col; out_last = out_valid && rd_col==3.
- Single-bank FSM, used when PINGPONG_EN is undefined:
  - FILL: in_ready=1, out_valid=0. Moves to DRAIN on the transfer of row 3.
  - DRAIN: in_ready=0, out_valid=1. Moves to FILL on the transfer of column 3.
- Output stability: while out_valid && !out_ready, out_re, out_im, out_col and out_last hold.
- Reset, from any state and even mid-frame:
  - in_ready=1, out_valid=0, out_col=0, out_last=0.
  - All pointers, bank flags and state are cleared, and any partial frame is discarded.
  - out_re/out_im read 0; the memory content is don't-care but the read mux is gated to 0 while !out_valid.

## Timing
- Latency: if row 3 transfers at edge E, out_valid is high in the cycle after E, presenting column 0.
- Throughput: 1 beat/cycle on each side with ready held high.
- Single bank: one frame takes 8 beats, with no write/read overlap. in_ready rises the cycle after column 3 transfers.
- Ping-pong (see Configuration): a sustained 4 beats/frame in and out.
- Simultaneous events:
  - Completing a fill of one bank and a drain of the other on the same edge sets and clears different flags. Both take effect, and there is no bubble.
  - in_valid during DRAIN (single bank) is ignored, because in_ready=0.
- All outputs come from registers or from a registered-pointer mux. There is no combinational path from in_valid to out_valid, or from out_ready to in_ready.

## Configuration
- PINGPONG_EN defined:
  - Two banks, with wr_bank, rd_bank and full[1:0].
  - in_ready = !full[wr_bank]; out_valid = full[rd_bank].
  - wr_bank toggles on row 3 transfer; rd_bank toggles on column 3 transfer.
  - Bank 0 is filled first after reset.
- PINGPONG_EN undefined: one bank, using the FILL/DRAIN FSM above. Storage is halved.

## Structure
- Shared package fft_pkg holds:
  - DATA_W and N
  - the cplx_t typedef (re/im, signed DATA_W)
  - the state enum {FILL, DRAIN}
- One sub-module, tb_bank_mem: a 4x4 complex register array with a full-row write port and a full-column read port. It is instantiated once, or twice under PINGPONG_EN.

## Test plan
- Load rows with re=16*r+c, im=-(16*r+c), out_ready=1:
  - Column c lanes r return re=16*r+c, im=-(16*r+c).
  - out_col=0..3; out_last only on column 3.
  - First out_valid appears 1 cycle after row 3 is accepted.
- Hold out_ready=0 for 5 cycles on column 1:
  - Outputs stay stable.
  - No data is lost; column 2 follows when ready returns.
- Single bank, offer frame 2 during the drain of frame 1: in_ready=0 until the cycle after column 3 transfers, after which frame 2 is accepted intact.
- PINGPONG_EN, back-to-back frames with in_valid=out_ready=1:
  - Steady state is 1 row in and 1 column out every cycle.
  - Frames are not mixed, e.g. frame values 0x0100+idx then 0x0200+idx.
- Assert rst after 2 rows of a frame: the next cycle shows in_ready=1, out_valid=0, out_re=0. A fresh full frame then transposes correctly with no stale rows.
- Extreme values 0x7FFF/0x8000 in re/im pass through unchanged.
